ctrl_exec_pipe: RTL and testbench

Parametrised, pipelined control-instruction execution lane for the out-of-order core. It does the following:
- Takes one issued control instruction per cycle and forwards operands from NUM_BYPASS bypass channels.
- Resolves conditional branches, JAL and JALR, and produces a registered writeback packet after LATENCY cycles.
- Holds the oldest outstanding mispredict as a redirect request to fetch, using a valid/ready handshake.
- Supports selective squash by sequence number.

---
 rtl/ctrl_exec_pipe.sv | 241 ++++++++++++++++++++++++
 tb/tb_ctrl_exec_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_exec_pipe.sv
`default_nettype none
// ctrl_exec_pipe: control-instruction execution lane (forwarding, branch/jump resolve,
// registered writeback, oldest-mispredict redirect, squash by seq). Revision 1.0
module ctrl_exec_pipe #(
  parameter int DATA_W     = 64,
  parameter int PC_W       = 64,
  parameter int PHY_W      = 7,
  parameter int SEQ_W      = 8,
  parameter int CTI_W      = 4,
  parameter int NUM_BYPASS = 4,
  parameter int LATENCY    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         exe_valid_i,
  input  logic [SEQ_W-1:0]             exe_seq_i,
  input  logic [PC_W-1:0]              exe_pc_i,
  input  logic [1:0]                   exe_ctrl_type_i,
  input  logic [2:0]                   exe_cond_i,
  input  logic [PHY_W-1:0]             exe_src1_tag_i,
  input  logic [PHY_W-1:0]             exe_src2_tag_i,
  input  logic [DATA_W-1:0]            exe_src1_data_i,
  input  logic [DATA_W-1:0]            exe_src2_data_i,
  input  logic [DATA_W-1:0]            exe_imm_i,
  input  logic [PC_W-1:0]              exe_pred_npc_i,
  input  logic                         exe_pred_dir_i,
  input  logic [PHY_W-1:0]             exe_dest_tag_i,
  input  logic                         exe_dest_valid_i,
  input  logic [CTI_W-1:0]             exe_cti_i,
  input  logic [NUM_BYPASS-1:0]        byp_valid_i,
  input  logic [NUM_BYPASS*PHY_W-1:0]  byp_tag_i,
  input  logic [NUM_BYPASS*DATA_W-1:0] byp_data_i,
  input  logic                         flush_i,
  input  logic [SEQ_W-1:0]             flush_seq_i,
  output logic                         wb_valid_o,
  output logic [SEQ_W-1:0]             wb_seq_o,
  output logic [PHY_W-1:0]             wb_dest_tag_o,
  output logic                         wb_dest_valid_o,
  output logic [DATA_W-1:0]            wb_data_o,
  output logic [PC_W-1:0]              wb_next_pc_o,
  output logic                         wb_dir_o,
  output logic                         wb_mispredict_o,
  output logic                         wb_exception_o,
  output logic [CTI_W-1:0]             wb_cti_o,
  output logic                         redirect_valid_o,
  input  logic                         redirect_ready_i,
  output logic [PC_W-1:0]              redirect_pc_o,
  output logic [SEQ_W-1:0]             redirect_seq_o,
  output logic [CTI_W-1:0]             redirect_cti_o
);

  localparam logic [1:0] CT_BR   = 2'd0;
  localparam logic [1:0] CT_JAL  = 2'd1;
  localparam logic [1:0] CT_JALR = 2'd2;

  if (!(LATENCY == 1 || LATENCY == 2)) begin : g_bad_latency
    $error("ctrl_exec_pipe: LATENCY must be 1 or 2");
  end

  // Resolution compares next_pc against pred_npc, so the direction hint is not needed.
  logic unused_pred_dir;
  assign unused_pred_dir = exe_pred_dir_i;

  function automatic logic younger(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] diff;
    diff = a - b;
    return (diff != '0) && !diff[SEQ_W-1];
  endfunction

  // Walk channels high to low so the lowest matching channel has the final say.
  logic [DATA_W-1:0] fwd1, fwd2;
  always_comb begin
    fwd1 = exe_src1_data_i;
    fwd2 = exe_src2_data_i;
    for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
      if (byp_valid_i[k] && byp_tag_i[k*PHY_W +: PHY_W] == exe_src1_tag_i)
        fwd1 = byp_data_i[k*DATA_W +: DATA_W];
      if (byp_valid_i[k] && byp_tag_i[k*PHY_W +: PHY_W] == exe_src2_tag_i)
        fwd2 = byp_data_i[k*DATA_W +: DATA_W];
    end
  end

  logic              c_valid, c_dest_valid;
  logic [SEQ_W-1:0]  c_seq;
  logic [PC_W-1:0]   c_pc, c_pnpc;
  logic [1:0]        c_type;
  logic [2:0]        c_cond;
  logic [DATA_W-1:0] c_src1, c_src2, c_imm;
  logic [PHY_W-1:0]  c_dest_tag;
  logic [CTI_W-1:0]  c_cti;

  if (LATENCY == 2) begin : g_lat2
    logic              s1_valid_q, s1_dest_valid_q;
    logic [SEQ_W-1:0]  s1_seq_q;
    logic [PC_W-1:0]   s1_pc_q, s1_pnpc_q;
    logic [1:0]        s1_type_q;
    logic [2:0]        s1_cond_q;
    logic [DATA_W-1:0] s1_src1_q, s1_src2_q, s1_imm_q;
    logic [PHY_W-1:0]  s1_dest_tag_q;
    logic [CTI_W-1:0]  s1_cti_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid_q <= 1'b0;      s1_dest_valid_q <= 1'b0;
        s1_seq_q <= '0;          s1_pc_q <= '0;
        s1_pnpc_q <= '0;         s1_type_q <= '0;
        s1_cond_q <= '0;         s1_src1_q <= '0;
        s1_src2_q <= '0;         s1_imm_q <= '0;
        s1_dest_tag_q <= '0;     s1_cti_q <= '0;
      end else begin
        s1_valid_q      <= exe_valid_i && !(flush_i && younger(exe_seq_i, flush_seq_i));
        s1_dest_valid_q <= exe_dest_valid_i;
        s1_seq_q        <= exe_seq_i;
        s1_pc_q         <= exe_pc_i;
        s1_pnpc_q       <= exe_pred_npc_i;
        s1_type_q       <= exe_ctrl_type_i;
        s1_cond_q       <= exe_cond_i;
        s1_src1_q       <= fwd1;
        s1_src2_q       <= fwd2;
        s1_imm_q        <= exe_imm_i;
        s1_dest_tag_q   <= exe_dest_tag_i;
        s1_cti_q        <= exe_cti_i;
      end
    end

    assign c_valid = s1_valid_q;        assign c_dest_valid = s1_dest_valid_q;
    assign c_seq = s1_seq_q;            assign c_pc = s1_pc_q;
    assign c_pnpc = s1_pnpc_q;          assign c_type = s1_type_q;
    assign c_cond = s1_cond_q;          assign c_src1 = s1_src1_q;
    assign c_src2 = s1_src2_q;          assign c_imm = s1_imm_q;
    assign c_dest_tag = s1_dest_tag_q;  assign c_cti = s1_cti_q;
  end else begin : g_lat1
    assign c_valid = exe_valid_i;       assign c_dest_valid = exe_dest_valid_i;
    assign c_seq = exe_seq_i;           assign c_pc = exe_pc_i;
    assign c_pnpc = exe_pred_npc_i;     assign c_type = exe_ctrl_type_i;
    assign c_cond = exe_cond_i;         assign c_src1 = fwd1;
    assign c_src2 = fwd2;               assign c_imm = exe_imm_i;
    assign c_dest_tag = exe_dest_tag_i; assign c_cti = exe_cti_i;
  end

  logic [PC_W-1:0]   pc_plus4, target, next_pc;
  logic [DATA_W-1:0] res_data;
  logic              dir, exc, mis, c_live;
  always_comb begin
    pc_plus4 = c_pc + PC_W'(4);
    target   = c_pc + PC_W'(c_imm);
    res_data = '0;
    dir      = 1'b0;
    exc      = 1'b0;
    case (c_type)
      CT_BR: begin
        case (c_cond)
          3'd0:    dir = (c_src1 == c_src2);
          3'd1:    dir = (c_src1 != c_src2);
          3'd4:    dir = ($signed(c_src1) <  $signed(c_src2));
          3'd5:    dir = ($signed(c_src1) >= $signed(c_src2));
          3'd6:    dir = (c_src1 <  c_src2);
          3'd7:    dir = (c_src1 >= c_src2);
          default: exc = 1'b1;
        endcase
      end
      CT_JAL: begin
        dir      = 1'b1;
        res_data = DATA_W'(pc_plus4);
      end
      CT_JALR: begin
        dir      = 1'b1;
        target   = PC_W'(c_src1 + c_imm) & {{(PC_W-1){1'b1}}, 1'b0};
        res_data = DATA_W'(pc_plus4);
      end
      default: exc = 1'b1;
    endcase
    next_pc = dir ? target : pc_plus4;
    mis     = (next_pc != c_pnpc) && !exc;
    c_live  = c_valid && !(flush_i && younger(c_seq, flush_seq_i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_o <= 1'b0;      wb_seq_o <= '0;
      wb_dest_tag_o <= '0;     wb_dest_valid_o <= 1'b0;
      wb_data_o <= '0;         wb_next_pc_o <= '0;
      wb_dir_o <= 1'b0;        wb_mispredict_o <= 1'b0;
      wb_exception_o <= 1'b0;  wb_cti_o <= '0;
    end else begin
      wb_valid_o      <= c_live;
      wb_seq_o        <= c_seq;
      wb_dest_tag_o   <= c_dest_tag;
      wb_dest_valid_o <= c_dest_valid;
      wb_data_o       <= res_data;
      wb_next_pc_o    <= next_pc;
      wb_dir_o        <= dir;
      wb_mispredict_o <= mis;
      wb_exception_o  <= exc;
      wb_cti_o        <= c_cti;
    end
  end

  // A candidate replaces the pending redirect only if the pending one is gone or younger.
  logic             redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]  redir_pc_q, redir_pc_d;
  logic [SEQ_W-1:0] redir_seq_q, redir_seq_d;
  logic [CTI_W-1:0] redir_cti_q, redir_cti_d;
  logic             pend_alive, consumed, cand;
  always_comb begin
    pend_alive    = redir_valid_q && !(flush_i && younger(redir_seq_q, flush_seq_i));
    consumed      = redir_valid_q && redirect_ready_i;
    cand          = c_live && mis;
    redir_valid_d = pend_alive && !consumed;
    redir_pc_d    = redir_pc_q;
    redir_seq_d   = redir_seq_q;
    redir_cti_d   = redir_cti_q;
    if (cand && (!pend_alive || consumed || younger(redir_seq_q, c_seq))) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = next_pc;
      redir_seq_d   = c_seq;
      redir_cti_d   = c_cti;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      redir_seq_q   <= '0;
      redir_cti_q   <= '0;
    end else begin
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      redir_seq_q   <= redir_seq_d;
      redir_cti_q   <= redir_cti_d;
    end
  end

  assign redirect_valid_o = redir_valid_q;
  assign redirect_pc_o    = redir_pc_q;
  assign redirect_seq_o   = redir_seq_q;
  assign redirect_cti_o   = redir_cti_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_exec_pipe.sv
`default_nettype none
// tb_ctrl_exec_pipe: directed self-checking bench; LATENCY=1 and LATENCY=2 lanes share stimulus.
// Revision 1.0
module tb_ctrl_exec_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic         exe_valid;
  logic [7:0]   exe_seq;
  logic [63:0]  exe_pc;
  logic [1:0]   exe_type;
  logic [2:0]   exe_cond;
  logic [6:0]   t1, t2, dtag;
  logic [63:0]  d1, d2, imm, pnpc;
  logic         pdir, dval;
  logic [3:0]   cti;
  logic [3:0]   byp_valid;
  logic [27:0]  byp_tag;
  logic [255:0] byp_data;
  logic         flush;
  logic [7:0]   flush_seq;
  logic         ready;

  logic        o1_wv, o1_dv, o1_dir, o1_mis, o1_exc, o1_rv;
  logic [7:0]  o1_seq, o1_rseq;
  logic [6:0]  o1_dt;
  logic [63:0] o1_data, o1_npc, o1_rpc;
  logic [3:0]  o1_cti, o1_rcti;
  logic        o2_wv, o2_dv, o2_dir, o2_mis, o2_exc, o2_rv;
  logic [7:0]  o2_seq, o2_rseq;
  logic [6:0]  o2_dt;
  logic [63:0] o2_data, o2_npc, o2_rpc;
  logic [3:0]  o2_cti, o2_rcti;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ctrl_exec_pipe #(.LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .exe_valid_i(exe_valid), .exe_seq_i(exe_seq), .exe_pc_i(exe_pc),
    .exe_ctrl_type_i(exe_type), .exe_cond_i(exe_cond), .exe_src1_tag_i(t1), .exe_src2_tag_i(t2),
    .exe_src1_data_i(d1), .exe_src2_data_i(d2), .exe_imm_i(imm), .exe_pred_npc_i(pnpc),
    .exe_pred_dir_i(pdir), .exe_dest_tag_i(dtag), .exe_dest_valid_i(dval), .exe_cti_i(cti),
    .byp_valid_i(byp_valid), .byp_tag_i(byp_tag), .byp_data_i(byp_data),
    .flush_i(flush), .flush_seq_i(flush_seq),
    .wb_valid_o(o1_wv), .wb_seq_o(o1_seq), .wb_dest_tag_o(o1_dt), .wb_dest_valid_o(o1_dv),
    .wb_data_o(o1_data), .wb_next_pc_o(o1_npc), .wb_dir_o(o1_dir), .wb_mispredict_o(o1_mis),
    .wb_exception_o(o1_exc), .wb_cti_o(o1_cti), .redirect_valid_o(o1_rv),
    .redirect_ready_i(ready), .redirect_pc_o(o1_rpc), .redirect_seq_o(o1_rseq),
    .redirect_cti_o(o1_rcti)
  );

  ctrl_exec_pipe #(.LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .exe_valid_i(exe_valid), .exe_seq_i(exe_seq), .exe_pc_i(exe_pc),
    .exe_ctrl_type_i(exe_type), .exe_cond_i(exe_cond), .exe_src1_tag_i(t1), .exe_src2_tag_i(t2),
    .exe_src1_data_i(d1), .exe_src2_data_i(d2), .exe_imm_i(imm), .exe_pred_npc_i(pnpc),
    .exe_pred_dir_i(pdir), .exe_dest_tag_i(dtag), .exe_dest_valid_i(dval), .exe_cti_i(cti),
    .byp_valid_i(byp_valid), .byp_tag_i(byp_tag), .byp_data_i(byp_data),
    .flush_i(flush), .flush_seq_i(flush_seq),
    .wb_valid_o(o2_wv), .wb_seq_o(o2_seq), .wb_dest_tag_o(o2_dt), .wb_dest_valid_o(o2_dv),
    .wb_data_o(o2_data), .wb_next_pc_o(o2_npc), .wb_dir_o(o2_dir), .wb_mispredict_o(o2_mis),
    .wb_exception_o(o2_exc), .wb_cti_o(o2_cti), .redirect_valid_o(o2_rv),
    .redirect_ready_i(ready), .redirect_pc_o(o2_rpc), .redirect_seq_o(o2_rseq),
    .redirect_cti_o(o2_rcti)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [7:0] s, input logic [63:0] pc, input logic [1:0] ty,
                       input logic [2:0] cd, input logic [6:0] a_tag, input logic [63:0] a_dat,
                       input logic [6:0] b_tag, input logic [63:0] b_dat,
                       input logic [63:0] im, input logic [63:0] pn);
    exe_valid = 1'b1; exe_seq = s;  exe_pc = pc;   exe_type = ty; exe_cond = cd;
    t1 = a_tag;       d1 = a_dat;   t2 = b_tag;    d2 = b_dat;    imm = im;
    pnpc = pn;        dtag = s[6:0]; dval = 1'b1;  cti = s[3:0];  pdir = 1'b0;
  endtask

  task automatic idle();
    exe_valid = 1'b0;
  endtask

  task automatic jal(input logic [7:0] s, input logic [63:0] pc);
    issue(s, pc, 2'd1, 3'd0, 7'd0, 64'd0, 7'd0, 64'd0, 64'h10, pc + 64'd4);
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; flush = 1'b0; flush_seq = 8'd0;
    byp_valid = '0; byp_tag = '0; byp_data = '0;
    issue(8'd0, 64'd0, 2'd0, 3'd0, 7'd0, 64'd0, 7'd0, 64'd0, 64'd0, 64'd4);
    idle();
    repeat (3) @(negedge clk);
    chk("reset_wb_valid_l1", o1_wv, 0);
    chk("reset_wb_valid_l2", o2_wv, 0);
    chk("reset_redir_valid_l1", o1_rv, 0);
    chk("reset_npc_l2", o2_npc, 0);
    reset = 1'b0;

    // Forwarding priority: ch0 invalid, ch1 and ch3 both match tag 5, ch1 must win.
    @(negedge clk);
    issue(8'd1, 64'h1000, 2'd0, 3'd0, 7'd5, 64'd0, 7'd9, 64'd7, 64'h40, 64'h1004);
    byp_valid = 4'b1010;
    byp_tag[0 +: 7] = 7'd5;   byp_data[0 +: 64]   = 64'd99;
    byp_tag[7 +: 7] = 7'd5;   byp_data[64 +: 64]  = 64'd7;
    byp_tag[21 +: 7] = 7'd5;  byp_data[192 +: 64] = 64'd3;
    @(negedge clk);
    idle(); byp_valid = '0;
    chk("fwd_wv_l1", o1_wv, 1);
    chk("fwd_dir_l1", o1_dir, 1);
    chk("fwd_npc_l1", o1_npc, 64'h1040);
    chk("fwd_mis_l1", o1_mis, 1);
    chk("fwd_rv_l1", o1_rv, 1);
    chk("fwd_rpc_l1", o1_rpc, 64'h1040);
    chk("fwd_rseq_l1", o1_rseq, 1);
    chk("fwd_rv_l2_early", o2_rv, 0);
    @(negedge clk);
    chk("fwd_wv_pulse_l1", o1_wv, 0);
    chk("fwd_wv_l2", o2_wv, 1);
    chk("fwd_npc_l2", o2_npc, 64'h1040);
    chk("fwd_rpc_l2", o2_rpc, 64'h1040);
    chk("fwd_rv_l2", o2_rv, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("consume_rv_l1", o1_rv, 0);
    chk("consume_rv_l2", o2_rv, 0);

    // JALR: (0x2003 + 4) & ~1 = 0x2006, link = 0x104.
    issue(8'd2, 64'h100, 2'd2, 3'd0, 7'd20, 64'h2003, 7'd0, 64'd0, 64'd4, 64'h2006);
    @(negedge clk);
    idle();
    chk("jalr_npc_l1", o1_npc, 64'h2006);
    chk("jalr_data_l1", o1_data, 64'h104);
    chk("jalr_mis_l1", o1_mis, 0);
    chk("jalr_dir_l1", o1_dir, 1);
    chk("jalr_dtag_l1", o1_dt, 7'd2);
    @(negedge clk);
    chk("jalr_data_l2", o2_data, 64'h104);
    chk("jalr_mis_l2", o2_mis, 0);
    chk("jalr_rv_l1", o1_rv, 0);
    chk("jalr_rv_l2", o2_rv, 0);

    // Oldest mispredict wins while fetch is stalled.
    jal(8'd10, 64'h300);
    @(negedge clk);
    jal(8'd7, 64'h700);
    chk("ord_seq10_l1", o1_rseq, 10);
    chk("ord_pc10_l1", o1_rpc, 64'h310);
    @(negedge clk);
    jal(8'd12, 64'hC00);
    chk("ord_seq7_l1", o1_rseq, 7);
    chk("ord_pc7_l1", o1_rpc, 64'h710);
    chk("ord_seq10_l2", o2_rseq, 10);
    @(negedge clk);
    idle(); ready = 1'b1;
    chk("ord_keep7_l1", o1_rseq, 7);
    chk("ord_cti7_l1", o1_rcti, 4'd7);
    chk("ord_seq7_l2", o2_rseq, 7);
    @(negedge clk);
    chk("ord_clear_l1", o1_rv, 0);
    chk("ord_refill_rv_l2", o2_rv, 1);
    chk("ord_refill_seq_l2", o2_rseq, 12);
    chk("ord_refill_pc_l2", o2_rpc, 64'hC10);
    @(negedge clk);
    ready = 1'b0;
    chk("ord_clear_l2", o2_rv, 0);

    // Wrap-around: 3 is younger than 250.
    jal(8'd250, 64'hA00);
    @(negedge clk);
    jal(8'd3, 64'hB00);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("wrap_keep250_l1", o1_rseq, 250);
    chk("wrap_keep250_l2", o2_rseq, 250);
    flush = 1'b1; flush_seq = 8'd252;
    @(negedge clk);
    flush = 1'b0;
    chk("wrap_250_survives_l1", o1_rv, 1);
    chk("wrap_250_survives_l2", o2_rv, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    jal(8'd3, 64'hB00);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("wrap_seq3_l1", o1_rseq, 3);
    chk("wrap_pc3_l2", o2_rpc, 64'hB10);
    chk("wrap_rv3_l2", o2_rv, 1);
    flush = 1'b1; flush_seq = 8'd252;
    @(negedge clk);
    flush = 1'b0;
    chk("wrap_flush_l1", o1_rv, 0);
    chk("wrap_flush_l2", o2_rv, 0);

    // Flush mid-pipeline: seq 21 (in stage 1) and 22 (issuing) are squashed.
    issue(8'd20, 64'h2000, 2'd0, 3'd1, 7'd0, 64'd5, 7'd0, 64'd5, 64'h80, 64'h2004);
    @(negedge clk);
    issue(8'd21, 64'h2004, 2'd0, 3'd1, 7'd0, 64'd5, 7'd0, 64'd5, 64'h80, 64'h2008);
    chk("flush_s20_l1", o1_seq, 20);
    @(negedge clk);
    issue(8'd22, 64'h2008, 2'd0, 3'd1, 7'd0, 64'd5, 7'd0, 64'd5, 64'h80, 64'h200C);
    flush = 1'b1; flush_seq = 8'd20;
    chk("flush_wv20_l2", o2_wv, 1);
    chk("flush_s20_l2", o2_seq, 20);
    chk("flush_s21_l1", o1_seq, 21);
    @(negedge clk);
    idle(); flush = 1'b0;
    chk("flush_kill21_l2", o2_wv, 0);
    chk("flush_kill22_l1", o1_wv, 0);
    @(negedge clk);
    chk("flush_kill22_l2", o2_wv, 0);

    // Signed/unsigned compares, illegal type, reserved branch code.
    issue(8'd30, 64'h4000, 2'd0, 3'd4, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd0, 64'd1, 64'h20, 64'h4020);
    @(negedge clk);
    issue(8'd31, 64'h4000, 2'd0, 3'd6, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd0, 64'd1, 64'h20, 64'h4020);
    chk("blt_dir_l1", o1_dir, 1);
    chk("blt_npc_l1", o1_npc, 64'h4020);
    chk("blt_mis_l1", o1_mis, 0);
    @(negedge clk);
    issue(8'd32, 64'h5000, 2'd3, 3'd0, 7'd0, 64'd0, 7'd0, 64'd0, 64'h20, 64'h5555);
    chk("bltu_dir_l1", o1_dir, 0);
    chk("bltu_npc_l1", o1_npc, 64'h4004);
    chk("bltu_mis_l1", o1_mis, 1);
    @(negedge clk);
    issue(8'd33, 64'h6000, 2'd0, 3'd2, 7'd0, 64'd0, 7'd0, 64'd0, 64'h20, 64'h6000);
    chk("ill_exc_l1", o1_exc, 1);
    chk("ill_mis_l1", o1_mis, 0);
    chk("ill_dir_l1", o1_dir, 0);
    chk("ill_data_l1", o1_data, 0);
    @(negedge clk);
    idle();
    chk("cond2_exc_l1", o1_exc, 1);
    chk("cond2_mis_l1", o1_mis, 0);
    @(negedge clk);
    chk("pre_reset_rv_l1", o1_rv, 1);
    chk("pre_reset_rseq_l2", o2_rseq, 31);
    reset = 1'b1; ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; ready = 1'b0;
    chk("rst_rv_l1", o1_rv, 0);
    chk("rst_rv_l2", o2_rv, 0);
    chk("rst_rpc_l1", o1_rpc, 0);
    chk("rst_rseq_l2", o2_rseq, 0);
    chk("rst_wv_l2", o2_wv, 0);
    chk("rst_npc_l1", o1_npc, 0);
    chk("rst_exc_l1", o1_exc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
